// File: rtl/dmem_responder.sv
// dmem_responder: M-stage data-memory responder for the pipelined MIPS core.
// Serves byte/half/word loads and stores from an internal word-organised RAM.
// It adds WAIT_CYCLES wait states per access and holds the pipeline with stall.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        addr_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic       NO_WAIT  = (WAIT_CYCLES == 0) ? 1'b1 : 1'b0;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // Byte-lane write mask for a store of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] ofs);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      2'b00:   m = 4'b0001 << ofs;
      2'b01:   m = ofs[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate right-aligned store data so every candidate lane sees it.
  function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    r = 32'd0;
    case (size)
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Select the addressed byte/half of a RAM word, right-align and extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] ofs, input logic sgn);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    shifted = word >> {ofs, 3'b000};
    b       = shifted[7:0];
    h       = ofs[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, sgn_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem_q [DEPTH];

  logic              req_err_s;
  logic              accept_s;
  logic              commit_s;
  logic              c_we_s, c_sgn_s;
  logic [1:0]        c_size_s;
  logic [ADDR_W+1:0] c_addr_s;
  logic [31:0]       c_wdata_s;
  logic [31:0]       rd_word_s;
  logic [3:0]        wmask_s;
  logic [31:0]       wword_s;

  // Flag illegal sizes, misaligned halves/words and addresses beyond the RAM.
  always_comb begin
    req_err_s = 1'b0;
    case (req_size)
      2'b00:   req_err_s = 1'b0;
      2'b01:   req_err_s = req_addr[0];
      2'b10:   req_err_s = |req_addr[1:0];
      default: req_err_s = 1'b1;
    endcase
    if ((req_addr >> (ADDR_W + 2)) != 32'd0) begin
      req_err_s = 1'b1;
    end else begin
      req_err_s = req_err_s;
    end
  end

  // Pick the committing request: live inputs when committing straight from IDLE, else latched copy.
  always_comb begin
    accept_s = (state_q == ST_IDLE) && req_en && !req_err_s;
    if (state_q == ST_IDLE) begin
      c_we_s    = req_we;
      c_sgn_s   = req_signed;
      c_size_s  = req_size;
      c_addr_s  = req_addr[ADDR_W+1:0];
      c_wdata_s = req_wdata;
    end else begin
      c_we_s    = we_q;
      c_sgn_s   = sgn_q;
      c_size_s  = size_q;
      c_addr_s  = addr_q;
      c_wdata_s = wdata_q;
    end
    commit_s  = !rst && ((accept_s && NO_WAIT) || ((state_q == ST_WAIT) && (cnt_q == 4'd0)));
    rd_word_s = mem_q[c_addr_s[ADDR_W+1:2]];
    wmask_s   = lane_mask(c_size_s, c_addr_s[1:0]);
    wword_s   = store_align(c_size_s, c_wdata_s);
  end

  // FSM next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = NO_WAIT ? ST_DONE : ST_WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs; all forced low while reset is held.
  always_comb begin
    stall    = 1'b0;
    done     = 1'b0;
    addr_err = 1'b0;
    if (!rst) begin
      stall    = accept_s || (state_q == ST_WAIT);
      done     = (state_q == ST_DONE);
      addr_err = (state_q == ST_IDLE) && req_en && req_err_s;
    end else begin
      stall    = 1'b0;
    end
  end

  // State, counter, request latch and load result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        we_q    <= req_we;
        sgn_q   <= req_signed;
        size_q  <= req_size;
        addr_q  <= req_addr[ADDR_W+1:0];
        wdata_q <= req_wdata;
      end
      if (commit_s && !c_we_s) begin
        rdata_q <= load_ext(rd_word_s, c_size_s, c_addr_s[1:0], c_sgn_s);
      end
    end
  end

  // RAM byte-lane writes at the store commit edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_s && c_we_s) begin
      for (int l = 0; l < 4; l++) begin
        if (wmask_s[l]) begin
          mem_q[c_addr_s[ADDR_W+1:2]][8*l +: 8] <= wword_s[8*l +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_en2, req_en0;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata2, rdata0;
  logic        stall2, stall0, done2, done0, err2, err0;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_en(req_en2), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rdata(rdata2), .stall(stall2), .done(done2), .addr_err(err2)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_en(req_en0), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rdata(rdata0), .stall(stall0), .done(done0), .addr_err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_stall(input bit fast);
    return fast ? stall0 : stall2;
  endfunction
  function automatic logic cur_done(input bit fast);
    return fast ? done0 : done2;
  endfunction
  function automatic logic cur_err(input bit fast);
    return fast ? err0 : err2;
  endfunction
  function automatic logic [31:0] cur_rdata(input bit fast);
    return fast ? rdata0 : rdata2;
  endfunction

  // One accepted access: measures stall length, checks the done pulse and no re-issue.
  task automatic access(input bit fast, input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                        input string tag);
    int  n_stall;
    bit  seen;
    int  waits;
    waits = fast ? 0 : 2;
    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    if (fast) req_en0 = 1'b1; else req_en2 = 1'b1;
    n_stall = 0;
    seen    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (cur_done(fast)) begin
        seen = 1'b1;
        break;
      end
      if (cur_stall(fast)) n_stall++;
      @(negedge clk);
      if (!hold) begin
        req_en0 = 1'b0; req_en2 = 1'b0;
        req_addr = 32'h0000_0FFC; req_wdata = ~wd; req_we = ~we;
      end
    end
    check_eq({tag, " done seen"}, 32'(seen), 32'd1);
    check_eq({tag, " stall cycles"}, n_stall, waits + 1);
    check_eq({tag, " stall in done"}, 32'(cur_stall(fast)), 32'd0);
    @(negedge clk);
    req_en0 = 1'b0; req_en2 = 1'b0;
    #1;
    check_eq({tag, " done one cycle"}, 32'(cur_done(fast)), 32'd0);
    check_eq({tag, " no reissue"}, 32'(cur_stall(fast)), 32'd0);
  endtask

  // One rejected request: addr_err for one cycle, no stall.
  task automatic bad_req(input bit we, input logic [1:0] size, input logic [31:0] addr,
                         input string tag);
    @(negedge clk);
    req_we = we; req_size = size; req_signed = 1'b1; req_addr = addr; req_wdata = 32'h0BAD_0BAD;
    req_en2 = 1'b1;
    #1;
    check_eq({tag, " addr_err"}, 32'(err2), 32'd1);
    check_eq({tag, " stall"}, 32'(stall2), 32'd0);
    @(negedge clk);
    req_en2 = 1'b0;
    #1;
    check_eq({tag, " err pulse"}, 32'(err2), 32'd0);
    check_eq({tag, " no access"}, 32'(done2 | stall2), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_en2 = 1'b1; req_en0 = 1'b1;
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'd0;
    @(negedge clk); @(negedge clk); #1;
    check_eq("reset stall", 32'({stall2, stall0}), 32'd0);
    check_eq("reset done", 32'({done2, done0}), 32'd0);
    check_eq("reset err", 32'({err2, err0}), 32'd0);
    check_eq("reset rdata2", rdata2, 32'd0);
    check_eq("reset rdata0", rdata0, 32'd0);
    req_en2 = 1'b0; req_en0 = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Word store then load.
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, "sw 10");
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, "lw 10");
    check_eq("lw 10 rdata", rdata2, 32'hDEAD_BEEF);

    // Byte store and signed/unsigned byte loads.
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_5680, 1'b0, "sb 13");
    access(1'b0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, "lb 13");
    check_eq("lb 13 rdata", rdata2, 32'hFFFF_FF80);
    access(1'b0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, "lbu 13");
    check_eq("lbu 13 rdata", rdata2, 32'h0000_0080);
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, "lw 10b");
    check_eq("lw 10b rdata", rdata2, 32'h80AD_BEEF);

    // Halfword store and loads.
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD_8001, 1'b0, "sh 12");
    access(1'b0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, "lh 12");
    check_eq("lh 12 rdata", rdata2, 32'hFFFF_8001);
    access(1'b0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, "lhu 12");
    check_eq("lhu 12 rdata", rdata2, 32'h0000_8001);
    access(1'b0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, "lh 10");
    check_eq("lh 10 rdata", rdata2, 32'hFFFF_BEEF);
    access(1'b0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, "lb 11");
    check_eq("lb 11 rdata", rdata2, 32'hFFFF_FFBE);

    // Rejected requests leave RAM and rdata alone.
    bad_req(1'b1, 2'b10, 32'h11, "sw 11");
    bad_req(1'b0, 2'b01, 32'h13, "lh 13");
    bad_req(1'b0, 2'b11, 32'h10, "size 11");
    bad_req(1'b0, 2'b10, 32'h0000_1000, "lw 1000");
    bad_req(1'b1, 2'b10, 32'h0000_1010, "sw 1010");
    check_eq("err rdata kept", rdata2, 32'hFFFF_FFBE);
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, "lw 10c");
    check_eq("lw 10c rdata", rdata2, 32'h8001_BEEF);

    // Reset during WAIT discards the pending store.
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0, "sw 20 pre");
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h1234_5678;
    req_en2 = 1'b1;
    #1;
    check_eq("rst-test accept", 32'(stall2), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst mid stall", 32'(stall2), 32'd0);
    check_eq("rst mid done", 32'(done2), 32'd0);
    @(negedge clk); #1;
    check_eq("rst held outputs", 32'({stall2, done2, err2}), 32'd0);
    @(negedge clk);
    req_en2 = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("rst rdata cleared", rdata2, 32'd0);
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, "lw 20");
    check_eq("lw 20 rdata", rdata2, 32'hCAFE_F00D);

    // Zero wait states, req_en held through DONE.
    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'hA5A5_A5A5, 1'b1, "fast sw 0");
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, "fast lw 0");
    check_eq("fast lw 0 rdata", rdata0, 32'hA5A5_A5A5);
    check_eq("fast err idle", 32'(err0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
